jpu_operand_seq: RTL and testbench

JPU_OPERAND_SEQ -- requirements
Module: jpu_operand_seq

---
 rtl/jpu_pkg.sv | 43 ++++
 rtl/jpu_instr_decode.sv | 28 ++
 rtl/jpu_operand_seq.sv | 163 ++++++++++++++++
 tb/tb_jpu_operand_seq.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpu_pkg.sv
// Shared definitions for the JPU operand sequencer: opcode constants,
// instruction field positions, sequencer state encoding and the decoded
// instruction record passed from the decoder to the sequencer.
package jpu_pkg;

  localparam logic [3:0] OPC_NOP    = 4'h0;
  localparam logic [3:0] OPC_LOADI  = 4'h1;
  localparam logic [3:0] OPC_ALU_LO = 4'h2;
  localparam logic [3:0] OPC_ALU_HI = 4'h7;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS_MSB  = 8;
  localparam int RS_LSB  = 6;
  localparam int RT_MSB  = 5;
  localparam int RT_LSB  = 3;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ_A  = 3'd1,
    ST_READ_B  = 3'd2,
    ST_CAP_B   = 3'd3,
    ST_ALU_REQ = 3'd4,
    ST_WRITE   = 3'd5
  } state_t;

  typedef struct packed {
    logic       is_nop;
    logic       is_loadi;
    logic       is_alu;
    logic       is_illegal;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [7:0] imm8;
    logic [2:0] alu_op;
  } dec_t;

endpackage

// File: rtl/jpu_instr_decode.sv
// Purpose: split a 16-bit instruction word into class flags and fields.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the decoded word is used.
// Ports: i_instr (raw instruction word), o_dec (decoded record, dec_t).
module jpu_instr_decode
  import jpu_pkg::*;
(
  input  logic [15:0] i_instr,
  output dec_t        o_dec
);

  logic [3:0] w_opc;

  always_comb begin
    w_opc            = i_instr[OPC_MSB:OPC_LSB];
    o_dec            = '0;
    o_dec.is_nop     = (w_opc == OPC_NOP);
    o_dec.is_loadi   = (w_opc == OPC_LOADI);
    o_dec.is_alu     = (w_opc >= OPC_ALU_LO) && (w_opc <= OPC_ALU_HI);
    o_dec.is_illegal = !(o_dec.is_nop || o_dec.is_loadi || o_dec.is_alu);
    o_dec.rd         = i_instr[RD_MSB:RD_LSB];
    o_dec.rs         = i_instr[RS_MSB:RS_LSB];
    o_dec.rt         = i_instr[RT_MSB:RT_LSB];
    o_dec.imm8       = i_instr[IMM_MSB:IMM_LSB];
    o_dec.alu_op     = w_opc[2:0];
  end

endmodule

// File: rtl/jpu_operand_seq.sv
// Purpose: sequence one instruction at a time through RF reads, ALU request and RF write-back.
// Latency: ALU op accepted at edge 0 writes in cycle 5 (ALU ready at once); LOADI writes in cycle 1; NOP retires at accept.
// Backpressure: instr_ready only in IDLE; ALU_REQ holds its request until alu_ready or the wait limit expires.
// Ports: instr_valid/instr_ready/instr (instruction in), rf_* (register file), alu_* (ALU handshake),
//        err (illegal opcode / ALU timeout pulse), retire_count (retired instructions).
module jpu_operand_seq
  import jpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic        rf_enable_read,
  output logic        rf_enable_write,
  output logic [2:0]  rf_addr,
  output logic [15:0] rf_wdata,
  input  logic [15:0] rf_rdata,
  output logic        alu_valid,
  output logic [2:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic        alu_ready,
  input  logic [15:0] alu_result,
  output logic        err,
  output logic [15:0] retire_count
);

  // Value of the wait counter during the last ALU_REQ cycle that is allowed.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  dec_t        w_dec;
  logic        w_accept;
  logic        w_timeout;
  logic        w_retire;
  // Keeps instr_ready low while reset is asserted and rises on the first edge after release.
  logic        r_rdy_en;
  logic        r_err;
  logic [2:0]  r_rd;
  logic [2:0]  r_rs;
  logic [2:0]  r_rt;
  logic [2:0]  r_alu_op;
  logic [15:0] r_op_a;
  logic [15:0] r_op_b;
  logic [15:0] r_result;
  logic [15:0] r_retire;
  logic [7:0]  r_wait;

  jpu_instr_decode u_decode (
    .i_instr (instr),
    .o_dec   (w_dec)
  );

  always_comb begin
    w_next    = r_state;
    w_accept  = (r_state == ST_IDLE) && r_rdy_en && instr_valid;
    w_timeout = (r_state == ST_ALU_REQ) && !alu_ready &&
                (TIMEOUT_CYCLES != 0) && (r_wait == TO_LAST);
    w_retire  = (w_accept && w_dec.is_nop) || (r_state == ST_WRITE);
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept && w_dec.is_loadi) begin
          w_next = ST_WRITE;
        end else if (w_accept && w_dec.is_alu) begin
          w_next = ST_READ_A;
        end
      end
      ST_READ_A:  w_next = ST_READ_B;
      ST_READ_B:  w_next = ST_CAP_B;
      ST_CAP_B:   w_next = ST_ALU_REQ;
      ST_ALU_REQ: begin
        if (alu_ready) begin
          w_next = ST_WRITE;
        end else if (w_timeout) begin
          w_next = ST_IDLE;
        end
      end
      ST_WRITE:   w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_rdy_en <= 1'b0;
      r_err    <= 1'b0;
      r_rd     <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_alu_op <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_retire <= '0;
      r_wait   <= '0;
    end else begin
      r_state  <= w_next;
      r_rdy_en <= 1'b1;
      r_err    <= (w_accept && w_dec.is_illegal) || w_timeout;
      if (w_accept) begin
        r_rd     <= w_dec.rd;
        r_rs     <= w_dec.rs;
        r_rt     <= w_dec.rt;
        r_alu_op <= w_dec.alu_op;
        if (w_dec.is_loadi) begin
          r_result <= {8'h00, w_dec.imm8};
        end
      end
      // Read data lags its strobe by one cycle: rs data arrives in READ_B, rt data in CAP_B.
      if (r_state == ST_READ_B) begin
        r_op_a <= rf_rdata;
      end
      if (r_state == ST_CAP_B) begin
        r_op_b <= rf_rdata;
        r_wait <= '0;
      end
      if (r_state == ST_ALU_REQ) begin
        r_wait <= r_wait + 8'd1;
        if (alu_ready) begin
          r_result <= alu_result;
        end
      end
      if (w_retire) begin
        r_retire <= r_retire + 16'd1;
      end
    end
  end

  // Outputs come only from registered state and fields; idle buses are forced to zero.
  always_comb begin
    instr_ready     = (r_state == ST_IDLE) && r_rdy_en;
    rf_enable_read  = (r_state == ST_READ_A) || (r_state == ST_READ_B);
    rf_enable_write = (r_state == ST_WRITE);
    rf_addr         = '0;
    rf_wdata        = '0;
    alu_valid       = (r_state == ST_ALU_REQ);
    alu_op          = '0;
    alu_a           = '0;
    alu_b           = '0;
    unique case (r_state)
      ST_READ_A:  rf_addr = r_rs;
      ST_READ_B:  rf_addr = r_rt;
      ST_WRITE: begin
        rf_addr  = r_rd;
        rf_wdata = r_result;
      end
      ST_ALU_REQ: begin
        alu_op = r_alu_op;
        alu_a  = r_op_a;
        alu_b  = r_op_b;
      end
      default: ;
    endcase
    err          = r_err;
    retire_count = r_retire;
  end

endmodule

// File: tb/tb_jpu_operand_seq.sv
module tb_jpu_operand_seq;

  localparam int unsigned TO = 4;

  logic        clock;
  logic        reset_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        rf_enable_read;
  logic        rf_enable_write;
  logic [2:0]  rf_addr;
  logic [15:0] rf_wdata;
  logic [15:0] rf_rdata;
  logic        alu_valid;
  logic [2:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_ready;
  logic [15:0] alu_result;
  logic        err;
  logic [15:0] retire_count;

  int          checks;
  int          errors;
  logic [15:0] regs [8];      // register file contents as the bench serves them
  logic [15:0] exp_retire;    // retire count the reference expects
  int          n_nop;
  int          sel;

  jpu_operand_seq #(.TIMEOUT_CYCLES(TO)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .rf_enable_read  (rf_enable_read),
    .rf_enable_write (rf_enable_write),
    .rf_addr         (rf_addr),
    .rf_wdata        (rf_wdata),
    .rf_rdata        (rf_rdata),
    .alu_valid       (alu_valid),
    .alu_op          (alu_op),
    .alu_a           (alu_a),
    .alu_b           (alu_b),
    .alu_ready       (alu_ready),
    .alu_result      (alu_result),
    .err             (err),
    .retire_count    (retire_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // ALU behaviour the bench plays back; the sequencer only forwards it.
  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return a & b;
      3'd5:    return a | b;
      3'd6:    return a ^ b;
      default: return ~(a + b);
    endcase
  endfunction

  task automatic do_nop();
    check("nop_rdy_before", instr_ready, 1);
    instr_valid = 1'b1;
    instr = {4'h0, 12'($urandom)};
    step();
    instr_valid = 1'b0;
    exp_retire = exp_retire + 16'd1;
    check("nop_retire", retire_count, exp_retire);
    check("nop_rdy_after", instr_ready, 1);
    check("nop_strobes", {rf_enable_read, rf_enable_write, alu_valid, err}, 0);
  endtask

  task automatic do_loadi(input logic [2:0] rd, input logic [7:0] imm);
    check("ldi_rdy_before", instr_ready, 1);
    instr_valid = 1'b1;
    instr = {4'h1, rd, 1'($urandom), imm};
    step();
    instr = 16'($urandom);   // valid stays high with junk: must be ignored
    check("ldi_wr_en", rf_enable_write, 1);
    check("ldi_rd_en", rf_enable_read, 0);
    check("ldi_addr", rf_addr, rd);
    check("ldi_wdata", rf_wdata, {8'h00, imm});
    check("ldi_rdy_busy", instr_ready, 0);
    regs[rd] = {8'h00, imm};
    exp_retire = exp_retire + 16'd1;
    step();
    instr_valid = 1'b0;
    check("ldi_retire", retire_count, exp_retire);
    check("ldi_rdy_after", instr_ready, 1);
    check("ldi_idle_bus", {rf_enable_write, rf_addr, rf_wdata}, 0);
  endtask

  task automatic do_illegal(input logic [3:0] opc);
    check("ill_rdy_before", instr_ready, 1);
    instr_valid = 1'b1;
    instr = {opc, 12'($urandom)};
    step();
    instr_valid = 1'b0;
    check("ill_err", err, 1);
    check("ill_strobes", {rf_enable_read, rf_enable_write, alu_valid}, 0);
    check("ill_rdy", instr_ready, 1);
    check("ill_retire", retire_count, exp_retire);
    step();
    check("ill_err_clear", err, 0);
  endtask

  // ready_at: ALU_REQ cycle (1-based) in which alu_ready is given; 0 = never.
  task automatic do_alu(input logic [3:0] opc, input logic [2:0] rd, input logic [2:0] rs,
                        input logic [2:0] rt, input int ready_at);
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    bit          done;
    a = regs[rs];
    b = regs[rt];
    r = alu_fn(opc[2:0], a, b);
    done = 1'b0;
    check("alu_rdy_before", instr_ready, 1);
    instr_valid = 1'b1;
    instr = {opc, rd, rs, rt, 3'($urandom)};
    step();
    instr = 16'($urandom);
    rf_rdata = 16'($urandom);
    check("rda_en", {rf_enable_read, rf_enable_write}, 2'b10);
    check("rda_addr", rf_addr, rs);
    check("rda_rdy", instr_ready, 0);
    step();
    rf_rdata = a;
    check("rdb_en", {rf_enable_read, rf_enable_write}, 2'b10);
    check("rdb_addr", rf_addr, rt);
    step();
    rf_rdata = b;
    check("capb_strobes", {rf_enable_read, rf_enable_write, alu_valid}, 0);
    check("capb_bus", {rf_addr, alu_op, alu_a, alu_b}, 0);
    step();
    rf_rdata = 16'($urandom);
    for (int k = 1; k <= int'(TO) && !done; k++) begin
      check("areq_valid", alu_valid, 1);
      check("areq_op", alu_op, opc[2:0]);
      check("areq_a", alu_a, a);
      check("areq_b", alu_b, b);
      check("areq_rf", {rf_enable_read, rf_enable_write, rf_addr}, 0);
      if (k == ready_at) begin
        alu_ready = 1'b1;
        alu_result = r;
        done = 1'b1;
      end else begin
        alu_ready = 1'b0;
        alu_result = 16'($urandom);
      end
      step();
    end
    alu_ready = 1'b0;
    if (done) begin
      check("wr_en", {rf_enable_read, rf_enable_write}, 2'b01);
      check("wr_addr", rf_addr, rd);
      check("wr_data", rf_wdata, r);
      check("wr_alu_idle", {alu_valid, alu_op, alu_a, alu_b}, 0);
      check("wr_err", err, 0);
      regs[rd] = r;
      exp_retire = exp_retire + 16'd1;
      step();
    end else begin
      check("to_err", err, 1);
      check("to_nowrite", {rf_enable_write, alu_valid}, 0);
    end
    instr_valid = 1'b0;
    check("alu_rdy_after", instr_ready, 1);
    check("alu_retire", retire_count, exp_retire);
    step();
    check("alu_err_after", err, 0);
    check("alu_nowrite_after", rf_enable_write, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_retire = '0;
    reset_n = 1'b1;
    instr_valid = 1'b0;
    instr = '0;
    rf_rdata = '0;
    alu_ready = 1'b0;
    alu_result = '0;
    for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);

    // Reset state
    #1 reset_n = 1'b0;
    #1;
    check("rst_ctrl", {instr_ready, rf_enable_read, rf_enable_write, alu_valid, err}, 0);
    check("rst_bus", {rf_addr, rf_wdata, alu_op}, 0);
    check("rst_alu_ab", {alu_a, alu_b}, 0);
    check("rst_retire", retire_count, 0);
    step();
    step();
    reset_n = 1'b1;
    step();
    check("rel_rdy", instr_ready, 1);
    check("rel_retire", retire_count, 0);

    // LOADI r3 <- 0xA5
    do_loadi(3'd3, 8'hA5);
    check("ldi_first_retire", retire_count, 16'd1);

    // ADD r1 = r2 + r4 with immediate ALU acceptance
    regs[2] = 16'h1234;
    regs[4] = 16'h0011;
    do_alu(4'h2, 3'd1, 3'd2, 3'd4, 1);

    // Illegal opcode
    do_illegal(4'h9);

    // ALU never ready -> timeout; then ready on 3rd and on last allowed cycle
    do_alu(4'h5, 3'd6, 3'd0, 3'd7, 0);
    do_alu(4'h3, 3'd5, 3'd5, 3'd1, 3);
    do_alu(4'h7, 3'd2, 3'd3, 3'd2, int'(TO));

    // Back-to-back NOPs
    do_nop();
    do_nop();

    // Randomized mix
    for (int it = 0; it < 60; it++) begin
      sel = $urandom_range(0, 9);
      if (sel < 2) begin
        do_nop();
      end else if (sel == 2) begin
        do_loadi(3'($urandom), 8'($urandom));
      end else if (sel == 3) begin
        do_illegal(4'($urandom_range(8, 15)));
      end else begin
        do_alu(4'($urandom_range(2, 7)), 3'($urandom), 3'($urandom), 3'($urandom),
               $urandom_range(0, TO));
      end
    end

    // retire_count wrap
    n_nop = 65535 - int'(exp_retire);
    instr_valid = 1'b1;
    instr = 16'h0000;
    for (int i = 0; i < n_nop; i++) step();
    exp_retire = 16'hFFFF;
    check("wrap_ffff", retire_count, exp_retire);
    step();
    instr_valid = 1'b0;
    exp_retire = exp_retire + 16'd1;
    check("wrap_zero", retire_count, 16'h0000);
    check("wrap_model", retire_count, exp_retire);

    // Reset in the middle of ALU_REQ
    regs[1] = 16'h00F0;
    regs[2] = 16'h0F00;
    instr_valid = 1'b1;
    instr = {4'h4, 3'd7, 3'd1, 3'd2, 3'd0};
    step();
    instr_valid = 1'b0;
    step();
    rf_rdata = regs[1];
    step();
    rf_rdata = regs[2];
    step();
    check("mid_areq", alu_valid, 1);
    reset_n = 1'b0;
    #1;
    exp_retire = '0;
    check("mid_rst_ctrl", {instr_ready, rf_enable_read, rf_enable_write, alu_valid, err}, 0);
    check("mid_rst_bus", {rf_addr, rf_wdata, alu_op}, 0);
    check("mid_rst_alu_ab", {alu_a, alu_b}, 0);
    check("mid_rst_retire", retire_count, 0);
    step();
    step();
    reset_n = 1'b1;
    alu_ready = 1'b1;
    alu_result = 16'hBEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_nowrite", {rf_enable_write, alu_valid}, 0);
    end
    alu_ready = 1'b0;
    check("post_rst_rdy", instr_ready, 1);
    do_loadi(3'd7, 8'h3C);
    check("post_rst_retire", retire_count, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
